lsu_sram_slave: RTL and testbench
=================================

Name: lsu_sram_slave

Overview:
- Memory slave directly downstream of the LSU. It serves the LSU's read channel (ar/r) and write channel (aw/w/b).
- Holds word-addressed storage. Inserts a programmable response latency. Performs sub-word lane handling so the LSU always finds load data in the low bits.
- Replaces the zero-latency behavioural memory. It also serves as the bench model for LSU handshake verification.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit storage words (power of two).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 2, cycles from ar handshake to rvalid assertion (>=1).
- WR_LAT, 2, cycles from capture of both aw and w to bvalid assertion (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- araddr  in  32  read byte address
- arsize  in  2  read size: 0 byte, 1 half, 2 word
- arvalid  in  1  read address valid
- arready  out  1  read address accept
- rdata  out  32  read data, addressed byte/half right-justified to bit 0
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data accept
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address accept
- wdata  in  32  write data, right-justified (byte in [7:0], half in [15:0])
- wstrb  in  3  one-hot size code: 3'd1 byte, 3'd2 half, 3'd4 word
- wvalid  in  1  write data valid
- wready  out  1  write data accept
- bvalid  out  1  write response valid
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- bready  in  1  write response accept

Behaviour:
- Interface fixed: single clock clk; rst asynchronous, active-high.
- Reset values: arready=1, rvalid=0, rdata=0, rresp=0, awready=1, wready=1, bvalid=0, bresp=0; both FSMs in IDLE; latency counters 0.
- Storage is not reset. Contents are retained across rst.
- Read FSM, R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. arvalid&arready captures araddr/arsize, loads counter with RD_LAT-1, then R_WAIT.
  - R_WAIT: arready=0. Decrements the counter. At 0, samples storage into rdata/rresp, then R_RESP. rvalid rises exactly RD_LAT cycles after the handshake cycle.
  - R_RESP: rvalid=1; rdata/rresp held stable until rready. rvalid&rready returns to R_IDLE. arready=1 on the following cycle (no back-to-back accept in the response cycle).
- Read data: word = mem[(addr-BASE)>>2].
  - rdata = word >> (8*addr[1:0]).
  - Byte: upper 24 bits zero. Half: upper 16 bits zero. Sign extension is the LSU's job.
- Write FSM, W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1 until aw captured, then 0. wready=1 until w captured, then 0. aw and w are independent and may arrive in the same or different cycles.
  - When both are captured: counter loads WR_LAT-1, then W_WAIT.
  - W_WAIT: at counter 0, commits the write (if no error) and sets bresp, then W_RESP.
  - W_RESP: bvalid=1 held until bready. bvalid&bready returns to W_IDLE.
- Write lanes: lane = awaddr[1:0].
  - Byte: updates byte lane only.
  - Half: updates bytes lane and lane+1.
  - Word: updates all bytes.
  - Other bytes unchanged.
- Errors (SLVERR, no storage update, rdata=0 on reads):
  - Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - Half access with addr[0]=1, or word access with addr[1:0]!=0.
  - wstrb not one-hot, or arsize=3.
- Read and write channels are fully concurrent. If a read samples the same word in the same cycle the write commits, the read returns the pre-write value.
- Reset mid-operation: both FSMs return to IDLE immediately and pending responses are dropped. A write not yet committed never modifies storage.
- Input addresses/data must be stable only in the handshake cycle. They are latched internally.

Decomposition:
- Shared package: size codes (SZ_B/SZ_H/SZ_W), wstrb one-hot constants, RESP_OKAY/RESP_SLVERR, read and write FSM state enums.
- One natural sub-module: lsu_sram_lane. It is combinational: it takes addr[1:0], size and word and produces the read shift, write byte-enable mask, merged write word and misalign flag. It is shared by both channels.

Test Plan:
- Write word 0xDEADBEEF at 0x8000_0010, wstrb=4, aw and w in the same cycle -> bvalid exactly 2 cycles after capture, bresp=0. Then read arsize=2 -> rvalid 2 cycles after ar handshake, rdata=0xDEADBEEF.
- Byte write 0x5A at 0x8000_0013 over the prior word -> word reads 0x5AADBEEF. Byte read at 0x8000_0011 -> rdata=0x000000BE.
- Separate aw/w arrival: awvalid at cycle 0, wvalid at cycle 3 -> awready drops after cycle 0, wready stays 1 until cycle 3, bvalid at cycle 3+WR_LAT.
- Backpressure: rready held 0 for 5 cycles -> rvalid and rdata stay stable. arready=0 throughout, and returns to 1 the cycle after the rready handshake.
- Errors: half write at 0x8000_0001 and read at 0x7FFF_FFFC -> SLVERR, storage unchanged, rdata=0.
- Assert rst during W_WAIT of a write of 0x11223344 -> bvalid=0, awready=1 immediately. A later read of that word returns the old value.

Source files
------------

// File: rtl/lsu_sram_slave_pkg.sv
// Shared encodings for the LSU SRAM slave: access sizes, write strobes,
// response codes and the read/write channel state types.
package lsu_sram_slave_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_BAD = 2'd3;

  localparam logic [2:0] WSTRB_B = 3'd1;
  localparam logic [2:0] WSTRB_H = 3'd2;
  localparam logic [2:0] WSTRB_W = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

  // Any strobe that is not exactly one of the three one-hot codes maps to SZ_BAD.
  function automatic logic [1:0] strb_to_size(input logic [2:0] strb);
    case (strb)
      WSTRB_B: return SZ_B;
      WSTRB_H: return SZ_H;
      WSTRB_W: return SZ_W;
      default: return SZ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_sram_slave_lane.sv
// Combinational byte-lane steering: right-justifies read data and merges
// sub-word write data into the stored word. One path per channel.
module lsu_sram_lane
  import lsu_sram_slave_pkg::*;
(
  input  logic [1:0]  rd_lane_i,
  input  logic [1:0]  rd_size_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] rd_data_o,
  output logic        rd_misalign_o,
  input  logic [1:0]  wr_lane_i,
  input  logic [1:0]  wr_size_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] wr_old_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_word_o,
  output logic        wr_misalign_o
);

  function automatic logic misaligned(input logic [1:0] lane, input logic [1:0] size);
    return ((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'd0));
  endfunction

  logic [31:0] rd_shift;
  logic [31:0] wr_shift;
  logic [3:0]  be;

  always_comb begin
    rd_shift = rd_word_i >> {rd_lane_i, 3'b000};
    case (rd_size_i)
      SZ_B:    rd_data_o = {24'd0, rd_shift[7:0]};
      SZ_H:    rd_data_o = {16'd0, rd_shift[15:0]};
      SZ_W:    rd_data_o = rd_shift;
      default: rd_data_o = 32'd0;
    endcase
    rd_misalign_o = misaligned(rd_lane_i, rd_size_i);
  end

  // An invalid size yields an empty byte-enable, which the top treats as an error.
  always_comb begin
    case (wr_size_i)
      SZ_B:    be = 4'b0001 << wr_lane_i;
      SZ_H:    be = 4'b0011 << wr_lane_i;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wr_shift = wr_data_i << {wr_lane_i, 3'b000};
    for (int i = 0; i < 4; i++) begin
      wr_word_o[8*i +: 8] = be[i] ? wr_shift[8*i +: 8] : wr_old_i[8*i +: 8];
    end
    wr_be_o       = be;
    wr_misalign_o = misaligned(wr_lane_i, wr_size_i);
  end

endmodule

// File: rtl/lsu_sram_slave.sv
// Word-addressed SRAM slave for the LSU with independent read (ar/r) and
// write (aw/w/b) channels, programmable response latency and lane steering.
module lsu_sram_slave
  import lsu_sram_slave_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic [1:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [2:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam int          RCW   = $clog2(RD_LAT + 1);
  localparam int          WCW   = $clog2(WR_LAT + 1);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  rd_state_e      rstate_q, rstate_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;
  logic [31:0]    raddr_q;
  logic [1:0]     rsize_q;

  wr_state_e      wstate_q, wstate_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           aw_got_q, aw_got_d;
  logic           w_got_q, w_got_d;
  logic [1:0]     bresp_q, bresp_d;
  logic [31:0]    waddr_q;
  logic [31:0]    wdata_q;
  logic [2:0]     wstrb_q;
  logic           wcommit;

  logic [31:0]      rd_off, wr_off;
  logic [IDX_W-1:0] ridx, widx;
  logic             rd_oor, wr_oor, rerr, werr;
  logic [31:0]      rd_word, wr_old, lane_rdata, lane_wword;
  logic             rd_mis, wr_mis;
  logic [3:0]       wr_be;

  assign rd_off  = raddr_q - BASE_ADDR;
  assign wr_off  = waddr_q - BASE_ADDR;
  assign rd_oor  = ({1'b0, rd_off} >= SPAN);
  assign wr_oor  = ({1'b0, wr_off} >= SPAN);
  assign ridx    = rd_off[IDX_W+1:2];
  assign widx    = wr_off[IDX_W+1:2];
  assign rd_word = mem[ridx];
  assign wr_old  = mem[widx];

  lsu_sram_lane u_lane (
    .rd_lane_i     (raddr_q[1:0]),
    .rd_size_i     (rsize_q),
    .rd_word_i     (rd_word),
    .rd_data_o     (lane_rdata),
    .rd_misalign_o (rd_mis),
    .wr_lane_i     (waddr_q[1:0]),
    .wr_size_i     (strb_to_size(wstrb_q)),
    .wr_data_i     (wdata_q),
    .wr_old_i      (wr_old),
    .wr_be_o       (wr_be),
    .wr_word_o     (lane_wword),
    .wr_misalign_o (wr_mis)
  );

  assign rerr = rd_oor || rd_mis || (rsize_q == SZ_BAD);
  assign werr = wr_oor || wr_mis || (wr_be == 4'b0000);

  // Read channel
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    arready  = 1'b0;
    rvalid   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rcnt_d   = RCW'(RD_LAT - 1);
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rdata_d  = rerr ? 32'd0 : lane_rdata;
          rresp_d  = rerr ? RESP_SLVERR : RESP_OKAY;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= '0;
      rdata_q  <= 32'd0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (arready && arvalid) begin
      raddr_q <= araddr;
      rsize_q <= arsize;
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

  // Write channel: aw and w are collected independently before the latency count starts
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    bresp_d  = bresp_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    wcommit  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready  = !aw_got_q;
        wready   = !w_got_q;
        aw_got_d = aw_got_q || awvalid;
        w_got_d  = w_got_q || wvalid;
        if (aw_got_d && w_got_d) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wcnt_d   = WCW'(WR_LAT - 1);
          wstate_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          wcommit  = !werr;
          bresp_d  = werr ? RESP_SLVERR : RESP_OKAY;
          wstate_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      wcnt_q   <= '0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      wcnt_q   <= wcnt_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      bresp_q  <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (awready && awvalid) waddr_q <= awaddr;
    if (wready && wvalid) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  assign bresp = bresp_q;

  // Storage is deliberately outside the reset domain; wcommit is low whenever rst holds the FSM idle.
  always_ff @(posedge clk) begin
    if (wcommit) mem[widx] <= lane_wword;
  end

endmodule

// File: tb/tb_lsu_sram_slave.sv
// Directed bench for lsu_sram_slave: a transaction-level memory model checked
// every cycle, plus literal expectations on latency and data.
module tb_lsu_sram_slave;

  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 2;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [1:0]  arsize, rresp, bresp;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [2:0]  wstrb;

  lsu_sram_slave #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference memory: bytes addressed by plain byte arithmetic
  logic [31:0] mm [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mm[i] = 32'd0;

  function automatic int nb_of_size(input logic [1:0] sz);
    case (sz) 2'd0: return 1; 2'd1: return 2; 2'd2: return 4; default: return 0; endcase
  endfunction

  function automatic int nb_of_strb(input logic [2:0] s);
    case (s) 3'd1: return 1; 3'd2: return 2; 3'd4: return 4; default: return 0; endcase
  endfunction

  function automatic bit m_err(input logic [31:0] a, input int nb);
    if ({1'b0, a} < {1'b0, BASE} || {1'b0, a} >= {1'b0, BASE} + 33'(4 * DEPTH)) return 1'b1;
    if (nb == 0) return 1'b1;
    return (int'(a[1:0]) % nb) != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input int nb);
    logic [31:0] w, v;
    int off;
    w = mm[int'((a - BASE) >> 2)];
    off = int'(a[1:0]);
    v = 32'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
    return v;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input int nb);
    int idx, off;
    idx = int'((a - BASE) >> 2);
    off = int'(a[1:0]);
    for (int i = 0; i < nb; i++) mm[idx][8*(off+i) +: 8] = d[8*i +: 8];
  endtask

  // Model of outstanding transactions and last response values
  bit          r_busy, r_vis, aw_have, w_have, w_pend, b_vis;
  int          r_samp, w_at, r_nb, w_nb, cyc;
  logic [31:0] r_a, w_a, w_d, rdata_e;
  logic [1:0]  rresp_e, bresp_e;

  initial cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      r_busy = 0; r_vis = 0; aw_have = 0; w_have = 0; w_pend = 0; b_vis = 0;
      rdata_e = 32'd0; rresp_e = 2'b00; bresp_e = 2'b00;
    end
    chk1("m_arready", arready, !r_busy);
    chk1("m_rvalid", rvalid, r_vis);
    chk("m_rdata", rdata, rdata_e);
    chk("m_rresp", {30'd0, rresp}, {30'd0, rresp_e});
    chk1("m_awready", awready, !w_pend && !b_vis && !aw_have);
    chk1("m_wready", wready, !w_pend && !b_vis && !w_have);
    chk1("m_bvalid", bvalid, b_vis);
    chk("m_bresp", {30'd0, bresp}, {30'd0, bresp_e});
    if (!rst) begin
      // Effects of the coming rising edge; read sampling precedes the write commit
      if (r_vis && rready) begin
        r_busy = 0; r_vis = 0;
      end else if (!r_busy && arvalid) begin
        r_busy = 1; r_a = araddr; r_nb = nb_of_size(arsize); r_samp = cyc + RD_LAT;
      end
      if (r_busy && !r_vis && cyc == r_samp) begin
        if (m_err(r_a, r_nb)) begin rdata_e = 32'd0; rresp_e = 2'b10; end
        else begin rdata_e = m_read(r_a, r_nb); rresp_e = 2'b00; end
        r_vis = 1;
      end
      if (b_vis && bready) begin
        b_vis = 0;
      end else if (!w_pend && !b_vis) begin
        if (!aw_have && awvalid) begin aw_have = 1; w_a = awaddr; end
        if (!w_have && wvalid) begin w_have = 1; w_d = wdata; w_nb = nb_of_strb(wstrb); end
        if (aw_have && w_have) begin
          aw_have = 0; w_have = 0; w_pend = 1; w_at = cyc + WR_LAT;
        end
      end
      if (w_pend && cyc == w_at) begin
        if (m_err(w_a, w_nb)) bresp_e = 2'b10;
        else begin m_write(w_a, w_d, w_nb); bresp_e = 2'b00; end
        w_pend = 0; b_vis = 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                    input int wlag, output int lat, output logic [1:0] resp);
    bit awd, wd, ah, wh;
    int k;
    awd = 0; wd = 0; k = 0;
    awaddr = a; awvalid = 1'b1;
    while (!(awd && wd) && k < 40) begin
      if (k == wlag) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      if (wlag > 0 && k >= 1 && k <= wlag) begin
        chk1("split_awready_low", awready, 1'b0);
        chk1("split_wready_high", wready, 1'b1);
      end
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      k++;
      if (ah) begin awd = 1; awvalid = 1'b0; awaddr = 32'h0BAD_0BAD; end
      if (wh) begin wd = 1; wvalid = 1'b0; wdata = 32'hFFFF_FFFF; wstrb = 3'd7; end
    end
    chk1("wr_handshake", awd && wd, 1'b1);
    lat = 0;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    resp = bresp;
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz, input int hold,
                    output logic [31:0] d, output logic [1:0] resp, output int lat);
    int k;
    araddr = a; arsize = sz; arvalid = 1'b1; rready = (hold == 0);
    k = 0;
    while (!arready && k < 20) begin tick(); k++; end
    tick();
    arvalid = 1'b0; araddr = 32'h0BAD_0BAD; arsize = 2'd3;
    lat = 0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    d = rdata; resp = rresp;
    for (int i = 0; i < hold; i++) begin
      chk1("hold_rvalid", rvalid, 1'b1);
      chk1("hold_arready", arready, 1'b0);
      tick();
    end
    rready = 1'b1;
    tick();
    chk1("arready_after_r", arready, 1'b1);
  endtask

  logic [31:0] d;
  logic [1:0]  resp;
  int          lat;

  initial begin
    rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    araddr = 32'd0; arsize = 2'd0; awaddr = 32'd0; wdata = 32'd0; wstrb = 3'd0;
    tick();
    chk1("rst_arready", arready, 1'b1);
    chk1("rst_awready", awready, 1'b1);
    chk1("rst_wready", wready, 1'b1);
    chk1("rst_rvalid", rvalid, 1'b0);
    chk1("rst_bvalid", bvalid, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    wr(32'h8000_0010, 32'hDEAD_BEEF, 3'd4, 0, lat, resp);
    chk("w1_lat", lat, 2); chk("w1_resp", {30'd0, resp}, 0);
    rd(32'h8000_0010, 2'd2, 0, d, resp, lat);
    chk("r1_lat", lat, 2); chk("r1_data", d, 32'hDEAD_BEEF); chk("r1_resp", {30'd0, resp}, 0);

    wr(32'h8000_0013, 32'h0000_005A, 3'd1, 0, lat, resp);
    chk("wb_resp", {30'd0, resp}, 0);
    rd(32'h8000_0010, 2'd2, 0, d, resp, lat);
    chk("rw_after_byte", d, 32'h5AAD_BEEF);
    rd(32'h8000_0011, 2'd0, 0, d, resp, lat);
    chk("rb_11", d, 32'h0000_00BE);
    rd(32'h8000_0012, 2'd1, 0, d, resp, lat);
    chk("rh_12", d, 32'h0000_5AAD);

    wr(32'h8000_0020, 32'hCAFE_F00D, 3'd4, 3, lat, resp);
    chk("split_lat", lat, 2); chk("split_resp", {30'd0, resp}, 0);
    rd(32'h8000_0022, 2'd1, 0, d, resp, lat);
    chk("rh_22", d, 32'h0000_CAFE);
    wr(32'h8000_0020, 32'h0000_1234, 3'd2, 0, lat, resp);
    rd(32'h8000_0020, 2'd2, 5, d, resp, lat);
    chk("bp_lat", lat, 2); chk("bp_data", d, 32'hCAFE_1234);

    wr(32'h8000_0000, 32'h0123_4567, 3'd4, 0, lat, resp);
    wr(32'h8000_0001, 32'h0000_FFFF, 3'd2, 0, lat, resp);
    chk("err_half_mis_resp", {30'd0, resp}, 2);
    wr(32'h8000_0000, 32'hFFFF_FFFF, 3'b011, 0, lat, resp);
    chk("err_strb_resp", {30'd0, resp}, 2);
    wr(32'h8000_1000, 32'hFFFF_FFFF, 3'd4, 0, lat, resp);
    chk("err_w_oor_resp", {30'd0, resp}, 2);
    rd(32'h8000_0000, 2'd2, 0, d, resp, lat);
    chk("err_unchanged", d, 32'h0123_4567);
    rd(32'h7FFF_FFFC, 2'd2, 0, d, resp, lat);
    chk("err_r_low_resp", {30'd0, resp}, 2); chk("err_r_low_data", d, 32'd0);
    rd(32'h8000_1000, 2'd0, 0, d, resp, lat);
    chk("err_r_high_resp", {30'd0, resp}, 2);
    rd(32'h8000_0000, 2'd3, 0, d, resp, lat);
    chk("err_r_size3_resp", {30'd0, resp}, 2); chk("err_r_size3_data", d, 32'd0);
    rd(32'h8000_0002, 2'd2, 0, d, resp, lat);
    chk("err_r_wmis_resp", {30'd0, resp}, 2);

    awaddr = 32'h8000_0010; wdata = 32'h1122_3344; wstrb = 3'd4;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk1("midrst_bvalid", bvalid, 1'b0);
    chk1("midrst_awready", awready, 1'b1);
    chk1("midrst_wready", wready, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    rd(32'h8000_0010, 2'd2, 0, d, resp, lat);
    chk("midrst_old_word", d, 32'h5AAD_BEEF);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
